// File: rtl/maxpool_seq.sv
// maxpool_seq
// Window sequencer for a single-accumulator max-pool unit. It takes convolution
// results that arrive window by window (POOL_K*POOL_K consecutive samples per
// window) and drives the accumulator load/compare/clear strobes. Each window
// maximum is captured into a valid/ready output register, and the last window
// of a feature map is flagged.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_flush                  abort current map, drop any partial window
//   i_valid/o_ready/i_data   conv sample stream (signed DW)
//   o_mp_clean               accumulator clean strobe
//   o_mp_read_clean          accumulator read-clean strobe (with clean: clear to 0)
//   o_mp_data                accumulator data input
//   i_mp_data                accumulator output, the running window maximum
//   o_valid/i_ready/o_data   pooled result stream (signed DW)
//   o_last                   result is the final window of the map
module maxpool_seq #(
  parameter int DW     = 16,
  parameter int POOL_K = 2,
  parameter int N_WIN  = 169
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [DW-1:0] i_data,
  output logic                 o_mp_clean,
  output logic                 o_mp_read_clean,
  output logic signed [DW-1:0] o_mp_data,
  input  logic signed [DW-1:0] i_mp_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [DW-1:0] o_data,
  output logic                 o_last
);

  localparam int WIN_N = POOL_K * POOL_K;
  localparam int SW    = $clog2(WIN_N + 1);
  localparam int WW    = (N_WIN > 1) ? $clog2(N_WIN) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(WIN_N - 1);
  localparam logic [WW-1:0] W_LAST = WW'(N_WIN - 1);

  // The most negative value never wins a compare, so driving it keeps the
  // accumulator unchanged on cycles where no sample is presented.
  localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_ACC,
    ST_CAPTURE
  } state_t;

  state_t          state;
  logic [SW-1:0]   s_cnt;
  logic [WW-1:0]   w_cnt;
  logic            acc;
  logic            cap_load;

  // Samples are taken in FIRST and ACC; CAPTURE is the one-cycle (or stalled)
  // slot where the accumulator output is moved into the result register.
  always_comb begin
    o_ready  = !i_rst && !i_flush && (state != ST_CAPTURE);
    acc      = i_valid && o_ready;
    cap_load = (state == ST_CAPTURE) && (!o_valid || i_ready);
  end

  // Accumulator strobes. The first sample of a window loads rather than
  // compares, so windows of all-negative values come out right.
  always_comb begin
    o_mp_clean      = 1'b0;
    o_mp_read_clean = 1'b0;
    o_mp_data       = MIN_VAL;
    if (!i_rst) begin
      if (i_flush) begin
        o_mp_clean      = 1'b1;
        o_mp_read_clean = 1'b1;
      end else if (acc) begin
        o_mp_data  = i_data;
        o_mp_clean = (state == ST_FIRST);
      end
    end
  end

  // Window state machine with sample count s_cnt and window count w_cnt.
  // s_cnt holds the number of samples already accepted in this window.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state <= ST_FIRST;
      s_cnt <= '0;
      w_cnt <= '0;
    end else begin
      case (state)
        ST_FIRST: begin
          if (acc) begin
            s_cnt <= SW'(1);
            state <= (WIN_N == 1) ? ST_CAPTURE : ST_ACC;
          end
        end
        ST_ACC: begin
          if (acc) begin
            s_cnt <= s_cnt + SW'(1);
            if (s_cnt == S_LAST) begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (cap_load) begin
            w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + WW'(1);
            state <= ST_FIRST;
          end
        end
        default: state <= ST_FIRST;
      endcase
    end
  end

  // Result register. A reload in the same cycle as a downstream accept
  // replaces the old result without dropping o_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (cap_load) begin
      o_valid <= 1'b1;
      o_data  <= i_mp_data;
      o_last  <= (w_cnt == W_LAST);
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_seq.sv
// tb_maxpool_seq
// Testbench for maxpool_seq with DW=16, POOL_K=2, N_WIN=3. A behavioural
// accumulator closes the loop from the strobes back to i_mp_data.
module tb_maxpool_seq;

  localparam int DW     = 16;
  localparam int POOL_K = 2;
  localparam int N_WIN  = 3;
  localparam int MINV   = -32768;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 valid_in;
  logic                 ready_out;
  logic signed [DW-1:0] data_in;
  logic                 mp_clean;
  logic                 mp_read_clean;
  logic signed [DW-1:0] mp_data_out;
  logic signed [DW-1:0] acc_q = '0;
  logic                 valid_out;
  logic                 ready_in;
  logic signed [DW-1:0] data_out;
  logic                 last_out;

  int errors = 0;
  int checks = 0;
  int win_count = 0;

  typedef struct {
    logic [3:0][DW-1:0] smp;
    logic [2:0][1:0]    gap;
    int                 exp_max;
  } vec_t;

  vec_t vecs[5];

  maxpool_seq #(.DW(DW), .POOL_K(POOL_K), .N_WIN(N_WIN)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_valid         (valid_in),
    .o_ready         (ready_out),
    .i_data          (data_in),
    .o_mp_clean      (mp_clean),
    .o_mp_read_clean (mp_read_clean),
    .o_mp_data       (mp_data_out),
    .i_mp_data       (acc_q),
    .o_valid         (valid_out),
    .i_ready         (ready_in),
    .o_data          (data_out),
    .o_last          (last_out)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Reference accumulator following the load / clear / compare contract.
  always @(posedge clk) begin
    if (mp_clean) acc_q <= mp_read_clean ? '0 : mp_data_out;
    else if (mp_data_out > acc_q) acc_q <= mp_data_out;
  end

  function automatic vec_t make_vec(input int s0, input int s1, input int s2, input int s3,
                                    input int g0, input int g1, input int g2, input int e);
    vec_t v;
    v.smp[0] = DW'(s0);
    v.smp[1] = DW'(s1);
    v.smp[2] = DW'(s2);
    v.smp[3] = DW'(s3);
    v.gap[0] = 2'(g0);
    v.gap[1] = 2'(g1);
    v.gap[2] = 2'(g2);
    v.exp_max = e;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle.
  task automatic applyStimulus(input logic rs, input logic fl, input logic v,
                               input logic signed [DW-1:0] d, input logic rdy);
    @(negedge clk);
    rst      = rs;
    flush    = fl;
    valid_in = v;
    data_in  = d;
    ready_in = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present the four samples of a window with the requested gaps.
  task automatic feedWindow(input vec_t v, input logic rdy);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, v.smp[k], rdy);
      checkOutput("ready_on_sample", ready_out, 1);
      checkOutput("mp_data_pass", mp_data_out, int'($signed(v.smp[k])));
      checkOutput("clean_first_only", mp_clean, (k == 0) ? 1 : 0);
      checkOutput("read_clean_low", mp_read_clean, 0);
      if (k < 3) begin
        for (int g = 0; g < int'(v.gap[k]); g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, rdy);
          checkOutput("gap_mp_data", mp_data_out, MINV);
          checkOutput("gap_clean", mp_clean, 0);
        end
      end
    end
  endtask

  // Capture cycle followed by the cycle in which the result is visible.
  task automatic captureAndCheck(input int exp_max, input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, rdy);
    checkOutput("capture_ready_low", ready_out, 0);
    checkOutput("acc_window_max", acc_q, exp_max);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, rdy);
    checkOutput("result_valid", valid_out, 1);
    checkOutput("result_data", data_out, exp_max);
    checkOutput("result_last", last_out, (win_count == N_WIN - 1) ? 1 : 0);
    win_count = (win_count + 1) % N_WIN;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;

    vecs[0] = make_vec(-5, -9, -2, -8, 0, 0, 0, -2);
    vecs[1] = make_vec(1, 4, 0, 2, 2, 1, 0, 4);
    vecs[2] = make_vec(-32768, -32768, -32768, -32768, 0, 0, 0, -32768);
    vecs[3] = make_vec(32767, 0, -1, 100, 1, 0, 0, 32767);
    vecs[4] = make_vec(-1, -3, 5, -100, 0, 0, 1, 5);

    // Reset: a valid sample must be ignored and everything held at rest.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'sd77, 1'b1);
    checkOutput("rst_ready", ready_out, 0);
    checkOutput("rst_clean", mp_clean, 0);
    checkOutput("rst_read_clean", mp_read_clean, 0);
    checkOutput("rst_mp_data", mp_data_out, MINV);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'sd77, 1'b1);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_last", last_out, 0);

    // Basic window 3,-7,9,2 with cycle-exact timing.
    feedWindow(make_vec(3, -7, 9, 2, 0, 0, 0, 9), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("t4_ready_low", ready_out, 0);
    checkOutput("t4_valid_low", valid_out, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("t5_valid", valid_out, 1);
    checkOutput("t5_data", data_out, 9);
    checkOutput("t5_last", last_out, 0);
    checkOutput("t5_ready_back", ready_out, 1);
    win_count = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("valid_drops_on_ready", valid_out, 0);

    // Table of windows; together with the first this gives six results,
    // so the last flag appears on results three and six.
    for (int i = 0; i < 5; i++) begin
      feedWindow(vecs[i], 1'b1);
      captureAndCheck(vecs[i].exp_max, 1'b1);
    end

    // Back-pressure: A is held while B accumulates, B waits in CAPTURE.
    feedWindow(make_vec(5, 5, 5, 5, 0, 0, 0, 5), 1'b0);
    captureAndCheck(5, 1'b0);
    feedWindow(make_vec(7, 1, 1, 1, 0, 0, 0, 7), 1'b0);
    checkOutput("a_held_valid", valid_out, 1);
    checkOutput("a_held_data", data_out, 5);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0);
      checkOutput("stall_ready_low", ready_out, 0);
      checkOutput("stall_valid", valid_out, 1);
      checkOutput("stall_data", data_out, 5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("release_ready_low", ready_out, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("b_valid_no_bubble", valid_out, 1);
    checkOutput("b_data", data_out, 7);
    checkOutput("b_last", last_out, (win_count == N_WIN - 1) ? 1 : 0);
    win_count = (win_count + 1) % N_WIN;
    checkOutput("b_ready_back", ready_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
    checkOutput("b_valid_drop", valid_out, 0);

    // Flush after two samples; the sample offered in the flush cycle is dropped.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'sd8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'sd9, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'sd50, 1'b1);
    checkOutput("flush_clean", mp_clean, 1);
    checkOutput("flush_read_clean", mp_read_clean, 1);
    checkOutput("flush_ready_low", ready_out, 0);
    win_count = 0;
    feedWindow(make_vec(1, 1, 1, 1, 0, 0, 0, 1), 1'b1);
    captureAndCheck(1, 1'b1);

    // Reset mid-window with a result pending.
    feedWindow(make_vec(2, 2, 2, 2, 0, 0, 0, 2), 1'b0);
    captureAndCheck(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'sd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'sd9, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'sd50, 1'b0);
    checkOutput("mid_rst_ready", ready_out, 0);
    checkOutput("mid_rst_clean", mp_clean, 0);
    checkOutput("mid_rst_mp_data", mp_data_out, MINV);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'sd50, 1'b0);
    checkOutput("mid_rst_valid", valid_out, 0);
    checkOutput("mid_rst_data", data_out, 0);
    checkOutput("mid_rst_last", last_out, 0);
    win_count = 0;
    feedWindow(make_vec(1, 1, 1, 1, 0, 0, 0, 1), 1'b1);
    captureAndCheck(1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_seq.md
# maxpool_seq

Window sequencer that drives the single-accumulator max-pool unit from a convolution output stream. It accepts conv results over a valid/ready handshake, already ordered window by window (POOL_K×POOL_K consecutive samples per window). It generates the accumulator's load, clear and compare strobes, captures each window maximum into an output register with valid/ready, and flags the last window of a feature map. It sits between the conv engine's output stage and the pooled-feature writeback.

## Interface
- `DW`: global data width from global.v. Signed two's complement.
- `POOL_K`, default 2: window side. One window is WIN_N = POOL_K² samples.
- `N_WIN`, default 169: windows per feature map (26×26 map pooled to 13×13).
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_flush`, in, 1: abort the current map. Discards any partial window.
- `i_valid`, in, 1: conv sample valid.
- `o_ready`, out, 1: sequencer accepts a sample.
- `i_data`, in, DW signed: conv sample.
- `o_mp_clean`, out, 1: accumulator clean strobe.
- `o_mp_read_clean`, out, 1: accumulator read-clean strobe.
- `o_mp_data`, out, DW signed: accumulator data input.
- `i_mp_data`, in, DW signed: accumulator output (the current window maximum).
- `o_valid`, out, 1: pooled result valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_data`, out, DW signed: pooled result.
- `o_last`, out, 1: the result is window N_WIN-1 of the map.

## Operation
- The accumulator contract is fixed:
  - clean=1, read_clean=0: load the data input.
  - clean=1, read_clean=1: clear to 0.
  - clean=0: register the data input only if it is greater than the held value.
  - The accumulator has no enable.
- Accept: `acc = i_valid && o_ready`.
- Strobe outputs are combinational from state and `acc`:
  - `acc` in FIRST: clean=1, read_clean=0, `o_mp_data = i_data`. The first sample loads, so all-negative windows are correct.
  - `acc` in ACC: clean=0, `o_mp_data = i_data`.
  - `i_flush`: clean=1, read_clean=1, regardless of state.
  - Otherwise: clean=0, read_clean=0, `o_mp_data = -2^(DW-1)`. The most negative value never wins a compare, so the accumulator holds.
- State machine:
  - FIRST: `o_ready = 1`. On `acc`, set sample count s = 1. Go to CAPTURE if WIN_N == 1, else go to ACC.
  - ACC: `o_ready = 1`. On `acc`, s increments. If the accepted sample is s == WIN_N-1, go to CAPTURE.
  - CAPTURE: `o_ready = 0`. `i_mp_data` holds the window maximum.
    - If `!o_valid || i_ready`: load `o_data <= i_mp_data`, `o_valid <= 1`, `o_last <= (w == N_WIN-1)`. Window count w then increments, or wraps to 0 at N_WIN-1. Go to FIRST.
    - Else stay in CAPTURE.
- Output register: `o_valid` clears on `i_ready` unless it is reloaded in the same cycle. `o_data` and `o_last` are stable while `o_valid && !i_ready`.
- FIRST and ACC accept samples while a previous result is pending. Stalling happens only in CAPTURE.
- `i_flush` (priority below reset, above everything else):
  - Next state FIRST; s and w return to 0; `o_valid`, `o_last` cleared.
  - `o_ready = 0` in the flush cycle, and any `i_valid` sample in that cycle is dropped.
- `i_rst`:
  - state FIRST; s = w = 0.
  - `o_valid = 0`, `o_data = 0`, `o_last = 0`.
  - `o_ready = 0` while reset is high.
  - Strobes 0 and `o_mp_data = -2^(DW-1)` during reset.
  - Reset mid-window discards the partial window.

## Timing
- Samples are accepted on cycles t0..t(WIN_N-1). The accumulator updates at each of those edges.
- CAPTURE is cycle t(WIN_N). `o_valid` rises at cycle t(WIN_N+1) at the earliest. Latency from the last sample to result is 2 cycles.
- Sustained throughput is one window per WIN_N+1 cycles. `o_ready` is low exactly one cycle per window, plus any CAPTURE stall cycles.
- `i_valid` gaps insert idle cycles. The accumulator is unchanged during them.
- When `i_ready` rises during a CAPTURE stall, the pending result transfers and the new result loads in the same cycle. No bubble is inserted on `o_valid`.

## Test plan
- DW=16, K=2; samples 3, -7, 9, 2 on consecutive cycles from t0 -> `o_data` = 9 and `o_valid` = 1 at t5; `o_ready` = 0 at t4 only.
- Samples -5, -9, -2, -8 -> `o_data` = -2. This checks load-on-first, not clear-to-zero.
- Samples 1, gap, gap, 4, gap, 0, 2 -> `o_mp_data` = -32768 on every gap cycle; `o_data` = 4.
- Hold `i_ready` = 0; window A = 5,5,5,5, then window B = 7,1,1,1 -> A is held with `o_valid` = 1; the FSM sits in CAPTURE with `o_ready` = 0; one cycle after `i_ready` = 1, `o_data` = 7.
- N_WIN=3, six windows -> `o_last` = 1 on results 3 and 6 only.
- Flush after 2 samples of 8, 9, then 1, 1, 1, 1 -> the flush cycle shows clean = read_clean = 1; `o_data` = 1. Repeat with `i_rst` instead of flush -> same result, and all outputs are at reset values during reset.
